// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - fetch/memory-stage arbiter driving a single-beat Wishbone-style bus
// Optional feature: define BUS_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES bus cycles without bus_ack.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        stall_req_if,
  output logic        stall_req_mem,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS_IF  = 2'd1,
    BUS_MEM = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  // Remembers a flush seen while the bus cycle was in flight so its result is discarded.
  logic        flushed_q, flushed_d;
  logic        in_bus;
  logic        kill;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
`endif

  assign in_bus = (state_q == BUS_IF) || (state_q == BUS_MEM);
  assign kill   = flushed_q | flush;

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    flushed_d   = flushed_q;
`ifdef BUS_TIMEOUT_EN
    cnt_inc     = cnt_q + 1'b1;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        flushed_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d     = '0;
`endif
        if (!flush) begin
          if (mem_req) begin
            state_d = BUS_MEM;
            cyc_d   = 1'b1;
            we_d    = mem_we;
            sel_d   = mem_sel;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
          end else if (if_req) begin
            state_d = BUS_IF;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            sel_d   = 4'b1111;
            addr_d  = if_addr;
          end
        end
      end
      BUS_IF, BUS_MEM: begin
        if (flush) flushed_d = 1'b1;
        if (bus_ack) begin
          cyc_d   = 1'b0;
          state_d = DONE;
          if (!kill) begin
            if (state_q == BUS_MEM) begin
              mem_rdata_d = bus_rdata;
              mem_ack_d   = 1'b1;
            end else begin
              if_rdata_d  = bus_rdata;
              if_ack_d    = 1'b1;
            end
          end
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_inc == CNT_LIMIT) begin
          cyc_d   = 1'b0;
          state_d = DONE;
          err_d   = 1'b1;
          cnt_d   = cnt_inc;
          if (!kill) begin
            if (state_q == BUS_MEM) begin
              mem_rdata_d = 32'h0;
              mem_ack_d   = 1'b1;
            end else begin
              if_rdata_d  = 32'h0;
              if_ack_d    = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      DONE: begin
        state_d   = IDLE;
        flushed_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset drops the bus cycle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'b0000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      flushed_q   <= flushed_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Timeout counter and one-cycle error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  // A flush arriving in DONE still cancels the already-registered ack.
  assign if_ack    = if_ack_q & ~flush;
  assign mem_ack   = mem_ack_q & ~flush;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  assign stall_req_if  = if_req & ~if_ack;
  assign stall_req_mem = mem_req & ~mem_ack;

  assign bus_cyc   = cyc_q;
  assign bus_stb   = cyc_q;
  assign bus_we    = we_q;
  assign bus_sel   = sel_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  logic unused_in_bus;
  assign unused_in_bus = in_bus;

endmodule
